// File: rtl/frame_row_writer_pkg.sv
// Shared definitions for the frame row writer: default geometry, derived
// frame sizes, FSM state encoding and a small counter-width helper.
package frame_row_writer_pkg;

  localparam int IMG_W_DFLT  = 64;
  localparam int IMG_H_DFLT  = 64;
  localparam int WORD_W_DFLT = 1;
  localparam int ADDR_W_DFLT = 12;

  localparam int BEATS_PER_ROW = IMG_W_DFLT / WORD_W_DFLT;
  localparam int FRAME_WORDS   = IMG_H_DFLT * BEATS_PER_ROW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2,
    ST_CLEAR = 2'd3
  } state_e;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frame_row_writer_if.sv
// Row-in / RAM-write-out bundle of the frame row writer.
// slave: the writer itself; master: whoever feeds rows and watches the RAM side.
interface frame_row_writer_if #(
  parameter int IMG_W  = frame_row_writer_pkg::IMG_W_DFLT,
  parameter int WORD_W = frame_row_writer_pkg::WORD_W_DFLT,
  parameter int ADDR_W = frame_row_writer_pkg::ADDR_W_DFLT
);
  logic              frame_start;
  logic              row_valid;
  logic [IMG_W-1:0]  row_data;
  logic              row_ready;
  logic [WORD_W-1:0] data;
  logic [ADDR_W-1:0] wraddress;
  logic              wren;
  logic              busy;
  logic              frame_done;

  modport master (
    output frame_start, row_valid, row_data,
    input  row_ready, data, wraddress, wren, busy, frame_done
  );

  modport slave (
    input  frame_start, row_valid, row_data,
    output row_ready, data, wraddress, wren, busy, frame_done
  );
endinterface

// File: rtl/frame_row_writer_row_serializer.sv
// Row serializer: parallel-loads one image row and hands it out WORD_W
// pixels per beat, LSB (x=0) first, with a beat counter and last-beat flag.
module row_serializer
  import frame_row_writer_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DFLT,
  parameter int WORD_W = WORD_W_DFLT,
  parameter int BEAT_W = cnt_width(IMG_W_DFLT / WORD_W_DFLT)
) (
  input  logic              clk,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [IMG_W-1:0]  row_i,
  output logic [WORD_W-1:0] word_o,
  output logic [BEAT_W-1:0] beat_o,
  output logic              last_beat_o
);
  localparam int BEATS = IMG_W / WORD_W;

  logic [IMG_W-1:0]  shift_q, shift_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  assign word_o      = shift_q[WORD_W-1:0];
  assign beat_o      = beat_q;
  assign last_beat_o = (beat_q == BEAT_W'(BEATS - 1));

  // Next shift/beat: load restarts the row, each shift consumes one beat and
  // the counter wraps to 0 after the last beat.
  always_comb begin
    shift_d = shift_q;
    beat_d  = beat_q;
    if (load_i) begin
      shift_d = row_i;
      beat_d  = '0;
    end else if (shift_i) begin
      shift_d = shift_q >> WORD_W;
      beat_d  = last_beat_o ? '0 : beat_q + BEAT_W'(1);
    end
  end

  // Beat counter is cleared by reset/frame restart; pixel data needs no reset.
  always_ff @(posedge clk) begin
    if (clr_i) beat_q <= '0;
    else       beat_q <= beat_d;
    shift_q <= shift_d;
  end

endmodule

// File: rtl/frame_row_writer.sv
// Frame row writer: accepts 1-bit-per-pixel image rows and writes them in
// raster order into the write port of the display frame RAM.
// Optional build macro FRAME_ROW_WRITER_CLEAR_EN: reset release and
// frame_start first zero the whole frame (CLEAR state) before rows are taken.
module frame_row_writer
  import frame_row_writer_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DFLT,
  parameter int IMG_H  = IMG_H_DFLT,
  parameter int WORD_W = WORD_W_DFLT,
  parameter int ADDR_W = ADDR_W_DFLT
) (
  input logic               clk,
  input logic               reset,
  frame_row_writer_if.slave bus
);
  localparam int BEATS  = IMG_W / WORD_W;
  localparam int WORDS  = IMG_H * BEATS;
  localparam int BEAT_W = cnt_width(BEATS);
  localparam int ROW_W  = cnt_width(IMG_H);

`ifdef FRAME_ROW_WRITER_CLEAR_EN
  localparam state_e START_ST = ST_CLEAR;
`else
  localparam state_e START_ST = ST_IDLE;
`endif

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_q;
  logic [ADDR_W-1:0] row_base_q;
  logic [WORD_W-1:0] hold_data_q;
  logic [ADDR_W-1:0] hold_addr_q;
  logic              load, shift, row_inc, row_zero;
  logic [WORD_W-1:0] ser_word;
  logic [BEAT_W-1:0] ser_beat;
  logic              ser_last;
  logic              wren_w;
  logic [WORD_W-1:0] data_w;
  logic [ADDR_W-1:0] addr_w;
`ifdef FRAME_ROW_WRITER_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr_q;
`endif

  row_serializer #(
    .IMG_W  (IMG_W),
    .WORD_W (WORD_W),
    .BEAT_W (BEAT_W)
  ) u_ser (
    .clk         (clk),
    .clr_i       (reset | bus.frame_start),
    .load_i      (load),
    .shift_i     (shift),
    .row_i       (bus.row_data),
    .word_o      (ser_word),
    .beat_o      (ser_beat),
    .last_beat_o (ser_last)
  );

  // Next state and row/serializer control; frame_start overrides everything.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    shift    = 1'b0;
    row_inc  = 1'b0;
    row_zero = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.row_valid) begin
          load    = 1'b1;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        shift = 1'b1;
        if (ser_last) begin
          if (row_q == ROW_W'(IMG_H - 1)) begin
            state_d = ST_DONE;
          end else begin
            row_inc = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DONE: begin
        row_zero = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
`ifdef FRAME_ROW_WRITER_CLEAR_EN
        if (clr_addr_q == ADDR_W'(WORDS - 1)) state_d = ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
    endcase
    if (bus.frame_start) begin
      state_d  = START_ST;
      load     = 1'b0;
      shift    = 1'b0;
      row_inc  = 1'b0;
      row_zero = 1'b1;
    end
  end

  // State register, row counter and the row's base address in the frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= START_ST;
      row_q      <= '0;
      row_base_q <= '0;
    end else begin
      state_q <= state_d;
      if (row_zero) begin
        row_q      <= '0;
        row_base_q <= '0;
      end else if (row_inc) begin
        row_q      <= row_q + ROW_W'(1);
        row_base_q <= row_base_q + ADDR_W'(BEATS);
      end
    end
  end

`ifdef FRAME_ROW_WRITER_CLEAR_EN
  // Clear sweep address: restarts on reset/frame_start, advances in CLEAR.
  always_ff @(posedge clk) begin
    if (reset || bus.frame_start) clr_addr_q <= '0;
    else if (state_q == ST_CLEAR) clr_addr_q <= clr_addr_q + ADDR_W'(1);
  end
`endif

  // RAM write triplet; data/address fall back to the last written beat.
  always_comb begin
    wren_w = 1'b0;
    data_w = hold_data_q;
    addr_w = hold_addr_q;
    if (state_q == ST_WRITE) begin
      wren_w = 1'b1;
      data_w = ser_word;
      addr_w = row_base_q + ADDR_W'(ser_beat);
    end
`ifdef FRAME_ROW_WRITER_CLEAR_EN
    else if (state_q == ST_CLEAR) begin
      wren_w = 1'b1;
      data_w = '0;
      addr_w = clr_addr_q;
    end
`endif
  end

  // Remember every written beat so the RAM bus stays stable between writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_data_q <= '0;
      hold_addr_q <= '0;
    end else if (wren_w) begin
      hold_data_q <= data_w;
      hold_addr_q <= addr_w;
    end
  end

  assign bus.wren       = wren_w;
  assign bus.data       = data_w;
  assign bus.wraddress  = addr_w;
  assign bus.row_ready  = (state_q == ST_IDLE);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.frame_done = (state_q == ST_DONE);

endmodule
